// File: rtl/bram_debug_sequencer.sv
// Loads the data and instruction BRAMs from a word stream, runs the core for RUN_CYCLES, then dumps the BRAMs.
// DUMP_INST_EN adds an instruction-RAM dump pass after the data-RAM dump; without it only the data RAM is dumped.
module bram_debug_sequencer #(
  parameter int unsigned WORDS      = 4096,
  parameter int unsigned RUN_CYCLES = 200000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_ram,
  output logic        out_last,
  output logic [31:0] dram_a2,
  output logic [31:0] dram_wd2,
  output logic [3:0]  dram_we2,
  input  logic [31:0] dram_rd2,
  output logic [31:0] iram_a2,
  output logic [31:0] iram_wd2,
  output logic [3:0]  iram_we2,
  input  logic [31:0] iram_rd2,
  output logic        core_rst,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);
  localparam logic [31:0]   RUN_LAST  = 32'(RUN_CYCLES - 1);
  localparam logic [31:0]   CRST_LAST = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_D, S_LOAD_I, S_CRST, S_RUN, S_DUMP_D, S_DUMP_I, S_DONE
  } state_e;
  typedef enum logic [1:0] {SUB_ADDR, SUB_WAIT, SUB_PRES} sub_e;

  state_e        state_q, state_d;
  sub_e          sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic [31:0]   cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d, out_ram_q, out_ram_d, out_last_q, out_last_d;
  logic [31:0]   out_data_q, out_data_d, out_addr_q, out_addr_d;
  logic [31:0]   dram_a2_q, dram_a2_d, dram_wd2_q, dram_wd2_d;
  logic [31:0]   iram_a2_q, iram_a2_d, iram_wd2_q, iram_wd2_d;
  logic [3:0]    dram_we2_q, dram_we2_d, iram_we2_q, iram_we2_d;
  logic          core_rst_q, core_rst_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]   rd_word;
  logic          final_ram;
  state_e        after_dump;

  function automatic logic [31:0] word_addr(input logic [IW-1:0] i);
    return 32'(i) << 2;
  endfunction

`ifdef DUMP_INST_EN
  assign rd_word    = (state_q == S_DUMP_I) ? iram_rd2 : dram_rd2;
  assign final_ram  = (state_q == S_DUMP_I);
  assign after_dump = (state_q == S_DUMP_D) ? S_DUMP_I : S_DONE;
`else
  logic [31:0] unused_iram_rd2;
  assign unused_iram_rd2 = iram_rd2;
  assign rd_word    = dram_rd2;
  assign final_ram  = 1'b1;
  assign after_dump = S_DONE;
`endif

  assign idx_inc  = idx_q + IW'(1);
  assign in_ready = (state_q == S_LOAD_D) || (state_q == S_LOAD_I);

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_ram_d   = out_ram_q;
    out_last_d  = out_last_q;
    dram_a2_d   = dram_a2_q;
    dram_wd2_d  = dram_wd2_q;
    iram_a2_d   = iram_a2_q;
    iram_wd2_d  = iram_wd2_q;
    dram_we2_d  = 4'h0;
    iram_we2_d  = 4'h0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD_D;
          idx_d   = '0;
        end
      end
      S_LOAD_D, S_LOAD_I: begin
        if (in_valid) begin
          if (state_q == S_LOAD_D) begin
            dram_a2_d  = word_addr(idx_q);
            dram_wd2_d = in_data;
            dram_we2_d = 4'hF;
          end else begin
            iram_a2_d  = word_addr(idx_q);
            iram_wd2_d = in_data;
            iram_we2_d = 4'hF;
          end
          if (in_last || idx_q == LAST_IDX) begin
            state_d = (state_q == S_LOAD_D) ? S_LOAD_I : S_CRST;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      S_CRST: begin
        if (cnt_q == CRST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d   = S_DUMP_D;
          sub_d     = SUB_ADDR;
          idx_d     = '0;
          dram_a2_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DUMP_D, S_DUMP_I: begin
        // a2 is already on the port during ADDR, so rd2 is valid during WAIT
        case (sub_q)
          SUB_ADDR: sub_d = SUB_WAIT;
          SUB_WAIT: begin
            sub_d       = SUB_PRES;
            out_valid_d = 1'b1;
            out_data_d  = rd_word;
            out_addr_d  = word_addr(idx_q);
            out_ram_d   = (state_q == S_DUMP_I);
            out_last_d  = final_ram && (idx_q == LAST_IDX);
          end
          default: begin
            if (out_ready) begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              sub_d       = SUB_ADDR;
              if (idx_q == LAST_IDX) begin
                state_d = after_dump;
                idx_d   = '0;
                if (after_dump == S_DUMP_I) iram_a2_d = '0;
              end else begin
                idx_d = idx_inc;
                if (state_q == S_DUMP_I) iram_a2_d = word_addr(idx_inc);
                else dram_a2_d = word_addr(idx_inc);
              end
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    core_rst_d = (state_d != S_RUN);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q     <= S_IDLE;
      sub_q       <= SUB_ADDR;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_ram_q   <= 1'b0;
      out_last_q  <= 1'b0;
      dram_a2_q   <= '0;
      dram_wd2_q  <= '0;
      dram_we2_q  <= '0;
      iram_a2_q   <= '0;
      iram_wd2_q  <= '0;
      iram_we2_q  <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_ram_q   <= out_ram_d;
      out_last_q  <= out_last_d;
      dram_a2_q   <= dram_a2_d;
      dram_wd2_q  <= dram_wd2_d;
      dram_we2_q  <= dram_we2_d;
      iram_a2_q   <= iram_a2_d;
      iram_wd2_q  <= iram_wd2_d;
      iram_we2_q  <= iram_we2_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_ram   = out_ram_q;
  assign out_last  = out_last_q;
  assign dram_a2   = dram_a2_q;
  assign dram_wd2  = dram_wd2_q;
  assign dram_we2  = dram_we2_q;
  assign iram_a2   = iram_a2_q;
  assign iram_wd2  = iram_wd2_q;
  assign iram_we2  = iram_we2_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Bench for bram_debug_sequencer: vector table, hand-written reset/restart sequences, and randomized full runs vs a reference model.
module tb_bram_debug_sequencer;
  localparam int WORDS      = 8;
  localparam int RUN_CYCLES = 10;
`ifdef DUMP_INST_EN
  localparam int NRAM = 2;
`else
  localparam int NRAM = 1;
`endif

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_ram, out_last, core_rst, busy, done;
  logic [31:0] out_data, out_addr, dram_a2, dram_wd2, iram_a2, iram_wd2;
  logic [3:0]  dram_we2, iram_we2;
  logic [31:0] dram_rd2, iram_rd2;

  bram_debug_sequencer #(.WORDS(WORDS), .RUN_CYCLES(RUN_CYCLES)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_ram(out_ram), .out_last(out_last),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
    .core_rst(core_rst), .busy(busy), .done(done)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) << 2) ^ 32'hFFFF0000;
  endfunction

  // BRAM models: synchronous read, one cycle latency
  logic [31:0] dmem [WORDS];
  logic [31:0] imem [WORDS];
  logic        mem_init = 1'b0;
  always @(posedge CPU_CLK) begin
    if (mem_init) begin
      for (int i = 0; i < WORDS; i++) begin
        dmem[i] <= pat(i);
        imem[i] <= pat(i);
      end
    end else begin
      if (dram_we2 != 4'h0) dmem[dram_a2[4:2]] <= dram_wd2;
      if (iram_we2 != 4'h0) imem[iram_a2[4:2]] <= iram_wd2;
    end
    dram_rd2 <= dmem[dram_a2[4:2]];
    iram_rd2 <= imem[iram_a2[4:2]];
  end

  typedef struct {logic [3:0] we; bit ram; logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {bit ram; bit last; logic [31:0] addr; logic [31:0] data; int cyc; int stalls; bit unstable;} dump_t;
  wr_t   wr_log[$];
  dump_t dump_log[$];
  int    cyc = 0, crst_low_total = 0, drop_bad = 0, stall_cnt = 0;
  bit    unstable = 0, holding = 0, prev_hs = 0;
  logic [31:0] hold_data, hold_addr;
  logic        hold_ram, hold_last;

  always @(posedge CPU_CLK) begin
    cyc++;
    if (core_rst == 1'b0) crst_low_total++;
    if (dram_we2 != 4'h0) wr_log.push_back('{dram_we2, 1'b0, dram_a2, dram_wd2});
    if (iram_we2 != 4'h0) wr_log.push_back('{iram_we2, 1'b1, iram_a2, iram_wd2});
    if (prev_hs && out_valid) drop_bad++;
    if (out_valid) begin
      if (holding && (out_data != hold_data || out_addr != hold_addr ||
                      out_ram != hold_ram || out_last != hold_last)) unstable = 1;
      if (out_ready) begin
        dump_log.push_back('{out_ram, out_last, out_addr, out_data, cyc, stall_cnt, unstable});
        stall_cnt = 0;
        unstable  = 0;
        holding   = 0;
      end else begin
        stall_cnt++;
        holding   = 1;
        hold_data = out_data;
        hold_addr = out_addr;
        hold_ram  = out_ram;
        hold_last = out_last;
      end
    end
    prev_hs = out_valid && out_ready;
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic run_seq(input bit from_reset, input int ld, input int li, input bit xl_d, input bit xl_i,
                         input bit rnd, input int gap_pct, input int rdy_pct, input bit stall2);
    logic [31:0] sw[$];
    bit          sl[$];
    logic [31:0] em [2][WORDS];
    wr_t         ew[$];
    int          wb, db, c0, d0, k, guard, stall_left, nexp;
    bit          stalled, hs;
    logic [31:0] exp_ia2;
    for (int i = 0; i < WORDS; i++) begin
      em[0][i] = pat(i);
      em[1][i] = pat(i);
    end
    for (int i = 0; i < ld + li; i++) begin
      bit r;
      int j, n;
      logic [31:0] w;
      r = (i >= ld);
      j = r ? i - ld : i;
      n = r ? li : ld;
      w = rnd ? $urandom : 32'h100 + 32'(i);
      sw.push_back(w);
      sl.push_back(j == n - 1 && (n < WORDS || (r ? xl_i : xl_d)));
      em[r][j] = w;
      ew.push_back('{4'hF, r, 32'(j) * 4, w});
    end
    if (from_reset) begin
      CPU_RST = 1'b1; tick; CPU_RST = 1'b0;
    end
    mem_init = 1'b1; tick; mem_init = 1'b0;
    wb = wr_log.size(); db = dump_log.size(); c0 = crst_low_total; d0 = drop_bad;
    start = 1'b1; tick; start = 1'b0;
    check("start_rdy", 96'(in_ready), 96'd1);
    k = 0; guard = 0;
    while (in_ready && guard < 500) begin
      in_valid = (k < sw.size()) && ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? sw[k] : $urandom;
      in_last  = in_valid ? sl[k] : 1'($urandom_range(1));
      hs = in_valid;
      tick;
      if (hs) k++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("load_consumed", 96'(k), 96'(ld + li));
    guard = 0; stalled = 0; stall_left = 0;
    while (!done && guard < 3000) begin
      if (stall2 && !stalled && out_valid && dump_log.size() - db == 2) begin
        stall_left = 7;
        stalled = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= rdy_pct);
      end
      tick;
      guard++;
    end
    out_ready = 1'b1;
    check("done_reached", 96'(done), 96'd1);
    check("end_idle_out", 96'({out_valid, busy}), 96'd0);
    check("run_len", 96'(crst_low_total - c0), 96'(RUN_CYCLES));
    check("valid_drop", 96'(drop_bad - d0), 96'd0);
    check("wr_count", 96'(wr_log.size() - wb), 96'(ew.size()));
    for (int e = 0; e < ew.size() && wb + e < wr_log.size(); e++)
      check("wr_entry", 96'({wr_log[wb+e].we, wr_log[wb+e].ram, wr_log[wb+e].addr, wr_log[wb+e].data}),
            96'({ew[e].we, ew[e].ram, ew[e].addr, ew[e].data}));
    nexp = NRAM * WORDS;
    check("dump_count", 96'(dump_log.size() - db), 96'(nexp));
    for (int e = 0; e < nexp && db + e < dump_log.size(); e++) begin
      int r, i;
      dump_t d;
      r = e / WORDS;
      i = e % WORDS;
      d = dump_log[db+e];
      check("dump_word", 96'({d.ram, d.last, d.addr, d.data}),
            96'({r[0], e == nexp - 1, 32'(i) * 4, em[r][i]}));
      check("dump_stable", 96'(d.unstable), 96'd0);
      if (e > 0) check("dump_spacing", 96'(d.cyc - dump_log[db+e-1].cyc), 96'(3 + d.stalls));
    end
    if (stall2 && db + 2 < dump_log.size()) check("stall_len", 96'(dump_log[db+2].stalls), 96'd7);
`ifdef DUMP_INST_EN
    exp_ia2 = 32'(WORDS - 1) * 4;
`else
    exp_ia2 = 32'(li - 1) * 4;
`endif
    check("final_a2", 96'({dram_a2, iram_a2}), 96'({32'(WORDS - 1) * 4, exp_ia2}));
  endtask

  typedef struct {
    bit st; bit vld; logic [31:0] dat; bit lst;
    bit rdy; bit bsy; logic [3:0] dwe; logic [31:0] da2; logic [31:0] dwd;
    logic [3:0] iwe; logic [31:0] ia2; logic [31:0] iwd;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{1, 0, 32'h0,  0, 1, 1, 4'h0, 32'h0, 32'h0,  4'h0, 32'h0, 32'h0};
    vt[1] = '{0, 1, 32'hA0, 0, 1, 1, 4'hF, 32'h0, 32'hA0, 4'h0, 32'h0, 32'h0};
    vt[2] = '{0, 1, 32'hA1, 0, 1, 1, 4'hF, 32'h4, 32'hA1, 4'h0, 32'h0, 32'h0};
    vt[3] = '{0, 0, 32'h0,  0, 1, 1, 4'h0, 32'h4, 32'hA1, 4'h0, 32'h0, 32'h0};
    vt[4] = '{0, 1, 32'hA2, 0, 1, 1, 4'hF, 32'h8, 32'hA2, 4'h0, 32'h0, 32'h0};
    vt[5] = '{0, 1, 32'hA3, 1, 1, 1, 4'hF, 32'hC, 32'hA3, 4'h0, 32'h0, 32'h0};
    vt[6] = '{1, 1, 32'hB0, 0, 1, 1, 4'h0, 32'hC, 32'hA3, 4'hF, 32'h0, 32'hB0};

    tick; tick;
    CPU_RST = 1'b0;
    check("rst_flags", 96'({in_ready, out_valid, out_last, out_ram, busy, done, core_rst}), 96'b0000001);
    check("rst_out", 96'({out_data, out_addr}), 96'd0);
    check("rst_dram", 96'({dram_a2, dram_wd2, dram_we2}), 96'd0);
    check("rst_iram", 96'({iram_a2, iram_wd2, iram_we2}), 96'd0);

    for (int r = 0; r < 7; r++) begin
      start = vt[r].st; in_valid = vt[r].vld; in_data = vt[r].dat; in_last = vt[r].lst;
      tick;
      check("vec_ctl", 96'({in_ready, busy, core_rst}), 96'({vt[r].rdy, vt[r].bsy, 1'b1}));
      check("vec_dram", 96'({dram_we2, dram_a2, dram_wd2}), 96'({vt[r].dwe, vt[r].da2, vt[r].dwd}));
      check("vec_iram", 96'({iram_we2, iram_a2, iram_wd2}), 96'({vt[r].iwe, vt[r].ia2, vt[r].iwd}));
    end
    start = 1'b0; in_last = 1'b0;
    for (int i = 1; i < 4; i++) begin
      in_data = 32'hB0 + 32'(i);
      tick;
    end
    check("inst_w3", 96'({iram_we2, iram_a2, iram_wd2}), 96'({4'hF, 32'hC, 32'hB3}));

    in_data = 32'hB4; CPU_RST = 1'b1;
    tick;
    CPU_RST = 1'b0; in_valid = 1'b0;
    check("midrst_we", 96'({dram_we2, iram_we2}), 96'd0);
    check("midrst_ctl", 96'({core_rst, busy, in_ready, done}), 96'b1000);
    tick;
    check("idle_hold", 96'({busy, in_ready}), 96'd0);
    start = 1'b1; tick; start = 1'b0;
    check("restart_rdy", 96'(in_ready), 96'd1);
    in_valid = 1'b1; in_data = 32'hC0;
    tick;
    in_valid = 1'b0;
    check("restart_addr", 96'({dram_we2, dram_a2, dram_wd2, iram_we2}), 96'({4'hF, 32'h0, 32'hC0, 4'h0}));

    run_seq(1'b1, WORDS, WORDS, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    start = 1'b1; tick; start = 1'b0;
    check("done_restart", 96'({in_ready, busy, done}), 96'b110);

    for (int n = 0; n < 3; n++)
      run_seq(1'b0, $urandom_range(WORDS, 1), $urandom_range(WORDS, 1), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'b1, 30, 40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bram_debug_sequencer.md
# bram_debug_sequencer

Synthesizable sequencer that drives the core's debug RAM ports (`CPU_Debug_DataRAM_*` / `CPU_Debug_InstRAM_*`) in place of a simulation bench.

- Accepts a 32-bit word stream and writes it into the data BRAM, then the instruction BRAM.
- Pulses the core out of reset, lets it run for a fixed cycle count, then reads both BRAMs back out as a word stream.
- Sits beside `RV32Core`, between a host link (UART/stream bridge) and the core's second BRAM port.

## Interface
Parameters:
- `WORDS`, 4096, words per BRAM (32-bit words; byte address = 4*index).
- `RUN_CYCLES`, 200000, cycles `core_rst` stays low in RUN; 32-bit count, must be ≥1.

Ports:
- `CPU_CLK` in 1: single clock.
- `CPU_RST` in 1: reset; one clock; reset is synchronous and active-high.
- `start` in 1: begin sequence; sampled only in IDLE or DONE.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32, `in_last` in 1: load stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_addr` out 32, `out_ram` out 1 (0=data, 1=inst), `out_last` out 1: dump stream.
- `dram_a2` out 32, `dram_wd2` out 32, `dram_we2` out 4, `dram_rd2` in 32: data BRAM debug port.
- `iram_a2` out 32, `iram_wd2` out 32, `iram_we2` out 4, `iram_rd2` in 32: instruction BRAM debug port.
- `core_rst` out 1: drives `RV32Core.CPU_RST`.
- `busy` out 1: high outside IDLE/DONE.
- `done` out 1: high in DONE.

## Operation
- States: IDLE → LOAD_D → LOAD_I → CRST → RUN → DUMP_D → DUMP_I → DONE. DONE + `start` re-enters LOAD_D.
- LOAD_D / LOAD_I:
  - `in_ready`=1.
  - Each handshake registers `a2`=4*idx, `wd2`=`in_data`, `we2`=4'b1111 for exactly one cycle on the active RAM. All other cycles `we2`=0.
  - Phase ends after the handshake with idx=`WORDS`-1 or with `in_last`=1; remaining addresses are left unwritten. idx is cleared at each phase change.
- CRST: `core_rst`=1 for 5 cycles, then RUN.
- `core_rst` is 1 in every state except RUN, including reset and IDLE.
- RUN: counter from 0; after exactly `RUN_CYCLES` cycles, enter DUMP_D.
- DUMP_D / DUMP_I: per word, three substeps.
  - ADDR: drive `a2`=4*idx.
  - WAIT: BRAM read latency is 1 cycle.
  - PRESENT: capture `rd2` into `out_data`, set `out_addr`=4*idx, assert `out_valid`.
  - `out_valid` holds and all `out_*` stay stable until `out_ready`.
  - `out_last`=1 only on idx=`WORDS`-1 of the final dumped RAM.
  - After the last word, `out_valid` drops the next cycle.
- `a2` holds its last value when not loading/dumping. `wd2` holds its last value.
- `start` while busy: ignored.
- `in_valid` outside LOAD: ignored, `in_ready`=0.
- `CPU_RST` mid-operation: next edge returns to IDLE with all outputs at reset values. A BRAM write in flight is dropped (`we2` forced 0).

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `out_ram`, `busy`, `done` = 0.
  - `out_data`, `out_addr`, all `a2`/`wd2`/`we2` = 0.
  - `core_rst` = 1.
- `start` at edge t → LOAD_D, `in_ready`=1 from t+1.
- Load throughput: 1 word/cycle; `we2` is registered one cycle after the handshake.
- RUN length is exactly `RUN_CYCLES` cycles with `core_rst`=0.
- Dump: minimum 3 cycles/word; each stalled cycle adds one.
- All outputs registered; no combinational in→out paths except `in_ready` (state decode only).

## Configuration
- `DUMP_INST_EN` defined: the sequence includes DUMP_I, and `out_last` marks the last instruction word.
- Undefined:
  - DUMP_I is skipped; DUMP_D goes straight to DONE.
  - `out_last` marks the last data word.
  - `iram_rd2` is unused.
  - `iram_a2` changes only during LOAD_I.

## Test plan
- `WORDS`=8, `RUN_CYCLES`=10; stream 16 words 0x100..0x10F, no `in_last` → `dram_we2` pulses at addresses 0x0..0x1C with 0x100..0x107; `iram_we2` pulses at 0x0..0x1C with 0x108..0x10F; `core_rst` low exactly 10 cycles.
- Load data RAM with `in_last` on word 3 (0xA0..0xA3) → only addresses 0x0..0xC written; LOAD_I starts next cycle at address 0x0.
- Dump with `out_ready` held 1, BRAM model returning addr^0xFFFF0000 → 8 data then 8 inst words, `out_addr` 0x0..0x1C, correct `out_ram`, `out_last` only on the 16th word, 3 cycles/word.
- `out_ready`=0 for 7 cycles on word 2 → `out_data`/`out_addr` stable for the whole stall; no word lost or duplicated.
- `CPU_RST` asserted mid-LOAD_I (word 4) → next cycle IDLE, `we2`=0, `core_rst`=1, `busy`=0; a fresh `start` restarts at data address 0x0.
- Without `DUMP_INST_EN` → only 8 words dumped, `out_last` on data address 0x1C, then `done`=1; `start` in DONE restarts LOAD_D.
